rc4_phase_scheduler: RTL and testbench

RC4_PHASE_SCHEDULER -- requirements
Module: rc4_phase_scheduler

---
 rtl/rc4_phase_scheduler.sv | 160 ++++++++++++++++
 tb/tb_rc4_phase_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_phase_scheduler.sv
// Sequences the RC4 INIT, KSA and PRGA engines, gives each a per-phase timeout,
// and arbitrates the shared S-memory port between the active engine and a debug host.
module rc4_phase_scheduler #(
   parameter int TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   output logic       init_start,
   output logic       ksa_start,
   output logic       prga_start,
   input  logic       init_done,
   input  logic       ksa_done,
   input  logic       prga_done,
   input  logic [7:0] init_addr,
   input  logic [7:0] ksa_addr,
   input  logic [7:0] prga_addr,
   input  logic [7:0] init_data,
   input  logic [7:0] ksa_data,
   input  logic [7:0] prga_data,
   input  logic       init_wren,
   input  logic       ksa_wren,
   input  logic       prga_wren,
   input  logic       dbg_req,
   input  logic [7:0] dbg_addr,
   input  logic [7:0] dbg_data,
   input  logic       dbg_wren,
   output logic       dbg_gnt,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_data,
   output logic       mem_wren,
   output logic [1:0] phase,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [3:0] {
      IDLE,
      INIT_ST,
      INIT_RUN,
      KSA_ST,
      KSA_RUN,
      PRGA_ST,
      PRGA_RUN,
      DONE,
      ERR
   } state_t;

   localparam logic [12:0] TIMEOUT_LAST = 13'(TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic [12:0] run_count;
   logic        is_run;
   logic        is_start;
   logic        is_rest;
   logic        timed_out;

   assign is_run    = (state == INIT_RUN) || (state == KSA_RUN) || (state == PRGA_RUN);
   assign is_start  = (state == INIT_ST) || (state == KSA_ST) || (state == PRGA_ST);
   assign is_rest   = (state == IDLE) || (state == DONE) || (state == ERR);
   assign timed_out = (run_count == TIMEOUT_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         run_count <= '0;
      end else begin
         state <= state_next;
         // Each X_ST cycle zeroes the counter so the following RUN phase starts at 0.
         if (is_start) begin
            run_count <= '0;
         end else if (is_run) begin
            run_count <= run_count + 13'd1;
         end
      end
   end

   always_comb begin
      state_next = state;
      if (abort) begin
         if (is_run || is_start) begin
            state_next = IDLE;
         end
      end else begin
         unique case (state)
            IDLE, DONE, ERR: if (start) state_next = INIT_ST;
            INIT_ST:  state_next = INIT_RUN;
            KSA_ST:   state_next = KSA_RUN;
            PRGA_ST:  state_next = PRGA_RUN;
            INIT_RUN: begin
               if (init_done)      state_next = KSA_ST;
               else if (timed_out) state_next = ERR;
            end
            KSA_RUN: begin
               if (ksa_done)       state_next = PRGA_ST;
               else if (timed_out) state_next = ERR;
            end
            PRGA_RUN: begin
               if (prga_done)      state_next = DONE;
               else if (timed_out) state_next = ERR;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Status and start pulses depend only on state; memory routing also looks at abort and the debug request.
   always_comb begin
      init_start = (state == INIT_ST);
      ksa_start  = (state == KSA_ST);
      prga_start = (state == PRGA_ST);
      busy       = is_run || is_start;
      done       = (state == DONE);
      error      = (state == ERR);
      phase      = 2'd0;
      dbg_gnt    = 1'b0;
      mem_addr   = 8'd0;
      mem_data   = 8'd0;
      mem_wren   = 1'b0;

      case (state)
         INIT_ST, INIT_RUN: phase = 2'd1;
         KSA_ST, KSA_RUN:   phase = 2'd2;
         PRGA_ST, PRGA_RUN: phase = 2'd3;
         default:           phase = 2'd0;
      endcase

      if (!abort) begin
         case (state)
            INIT_RUN: begin
               mem_addr = init_addr;
               mem_data = init_data;
               mem_wren = init_wren;
            end
            KSA_RUN: begin
               mem_addr = ksa_addr;
               mem_data = ksa_data;
               mem_wren = ksa_wren;
            end
            PRGA_RUN: begin
               mem_addr = prga_addr;
               mem_data = prga_data;
               mem_wren = prga_wren;
            end
            default: begin
               if (is_rest && dbg_req && !start) begin
                  dbg_gnt  = 1'b1;
                  mem_addr = dbg_addr;
                  mem_data = dbg_data;
                  mem_wren = dbg_wren;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_phase_scheduler.sv
// Directed bench for rc4_phase_scheduler: full sequence, timeout, arbitration,
// abort, spurious done pulses and mid-phase reset, with hand-computed expectations.
module tb_rc4_phase_scheduler;

   localparam int TO = 1024;

   logic       clk = 1'b0;
   logic       reset, start, abort;
   logic       init_start, ksa_start, prga_start;
   logic       init_done, ksa_done, prga_done;
   logic [7:0] init_addr, ksa_addr, prga_addr;
   logic [7:0] init_data, ksa_data, prga_data;
   logic       init_wren, ksa_wren, prga_wren;
   logic       dbg_req, dbg_wren, dbg_gnt;
   logic [7:0] dbg_addr, dbg_data;
   logic [7:0] mem_addr, mem_data;
   logic       mem_wren;
   logic [1:0] phase;
   logic       busy, done, error;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rc4_phase_scheduler #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
      .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
      .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
      .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
      .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_wren(dbg_wren),
      .dbg_gnt(dbg_gnt), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
      .phase(phase), .busy(busy), .done(done), .error(error)
   );

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Status snapshot: {init_start, ksa_start, prga_start, busy, done, error, phase}
   function automatic logic [7:0] status();
      return {init_start, ksa_start, prga_start, busy, done, error, phase};
   endfunction

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0;
      init_addr = 8'h11; init_data = 8'h22; init_wren = 1'b1;
      ksa_addr = 8'h3C; ksa_data = 8'h44; ksa_wren = 1'b1;
      prga_addr = 8'h77; prga_data = 8'h66; prga_wren = 1'b1;
      dbg_req = 1'b0; dbg_addr = 8'hA5; dbg_data = 8'h5A; dbg_wren = 1'b1;

      // Reset state
      cyc(2);
      reset = 1'b1;
      #1;
      chk("reset_status", status(), 8'b000_000_00);
      chk("reset_mem_addr", mem_addr, 8'h00);
      chk("reset_mem_wren", {7'd0, mem_wren}, 8'd0);
      chk("reset_dbg_gnt", {7'd0, dbg_gnt}, 8'd0);

      // Full run: INIT_ST one cycle after start
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      #1;
      chk("init_st_status", status(), 8'b100_100_01);
      chk("init_st_mem_wren", {7'd0, mem_wren}, 8'd0);
      cyc(1);
      chk("init_run_status", status(), 8'b000_100_01);
      chk("init_run_mem_addr", mem_addr, 8'h11);
      chk("init_run_mem_data", mem_data, 8'h22);
      // Spurious prga_done while INIT is running
      prga_done = 1'b1;
      cyc(1);
      prga_done = 1'b0;
      #1;
      chk("spurious_prga_done", status(), 8'b000_100_01);
      cyc(253);
      init_done = 1'b1;
      cyc(1);
      init_done = 1'b0;
      ksa_done = 1'b1;
      #1;
      chk("ksa_st_status", status(), 8'b010_100_10);
      // ksa_done during KSA_ST must be ignored
      cyc(1);
      ksa_done = 1'b0;
      #1;
      chk("ksa_done_in_st_ignored", status(), 8'b000_100_10);
      // Debug request during KSA_RUN loses to the engine
      dbg_req = 1'b1;
      #1;
      chk("ksa_run_dbg_gnt", {7'd0, dbg_gnt}, 8'd0);
      chk("ksa_run_mem_addr", mem_addr, 8'h3C);
      chk("ksa_run_mem_data", mem_data, 8'h44);
      dbg_req = 1'b0;
      cyc(765);
      ksa_done = 1'b1;
      cyc(1);
      ksa_done = 1'b0;
      #1;
      chk("prga_st_status", status(), 8'b001_100_11);
      cyc(1);
      chk("prga_run_mem_addr", mem_addr, 8'h77);
      cyc(298);
      prga_done = 1'b1;
      cyc(1);
      prga_done = 1'b0;
      #1;
      chk("done_status", status(), 8'b000_010_00);
      // Debug access in DONE is granted
      dbg_req = 1'b1;
      #1;
      chk("done_dbg_gnt", {7'd0, dbg_gnt}, 8'd1);
      chk("done_mem_addr", mem_addr, 8'hA5);
      chk("done_mem_data", mem_data, 8'h5A);
      chk("done_mem_wren", {7'd0, mem_wren}, 8'd1);
      dbg_req = 1'b0;
      cyc(3);
      chk("done_sticky", status(), 8'b000_010_00);

      // init_done on the last allowed cycle wins over timeout
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      #1;
      chk("restart_clears_done", status(), 8'b100_100_01);
      cyc(1);
      cyc(TO - 1);
      chk("init_last_cycle", status(), 8'b000_100_01);
      init_done = 1'b1;
      cyc(1);
      init_done = 1'b0;
      #1;
      chk("init_done_beats_timeout", status(), 8'b010_100_10);

      // KSA never finishes: ERR after TO cycles of KSA_RUN
      cyc(1);
      cyc(TO - 1);
      chk("ksa_before_timeout", status(), 8'b000_100_10);
      cyc(1);
      chk("timeout_err_status", status(), 8'b000_001_00);
      chk("timeout_mem_wren", {7'd0, mem_wren}, 8'd0);
      cyc(2);
      chk("err_sticky", status(), 8'b000_001_00);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      #1;
      chk("restart_clears_error", status(), 8'b100_100_01);

      // Abort during PRGA_RUN
      cyc(1);
      init_done = 1'b1;
      cyc(1);
      init_done = 1'b0;
      cyc(1);
      ksa_done = 1'b1;
      cyc(1);
      ksa_done = 1'b0;
      cyc(1);
      chk("prga_run_before_abort", status(), 8'b000_100_11);
      chk("prga_wren_routed", {7'd0, mem_wren}, 8'd1);
      abort = 1'b1;
      prga_done = 1'b1;
      #1;
      chk("abort_mem_wren", {7'd0, mem_wren}, 8'd0);
      chk("abort_mem_addr", mem_addr, 8'h00);
      cyc(1);
      abort = 1'b0;
      prga_done = 1'b0;
      #1;
      chk("after_abort_status", status(), 8'b000_000_00);

      // Start and debug request together in IDLE
      dbg_req = 1'b1;
      #1;
      chk("idle_dbg_gnt", {7'd0, dbg_gnt}, 8'd1);
      start = 1'b1;
      #1;
      chk("idle_start_blocks_gnt", {7'd0, dbg_gnt}, 8'd0);
      chk("idle_start_mem_wren", {7'd0, mem_wren}, 8'd0);
      dbg_req = 1'b0;

      // Reset in the middle of KSA
      cyc(1);
      start = 1'b0;
      cyc(1);
      init_done = 1'b1;
      cyc(1);
      init_done = 1'b0;
      cyc(1);
      chk("ksa_run_before_reset", status(), 8'b000_100_10);
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      #1;
      chk("midreset_status", status(), 8'b000_000_00);
      chk("midreset_mem_wren", {7'd0, mem_wren}, 8'd0);
      chk("midreset_mem_addr", mem_addr, 8'h00);
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("post_reset_quiet", status(), 8'b000_000_00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
